// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
// Field encodings for the writeback stage: destination-register select, writeback source
// select and load size. The reserved code 3 of each field has no enumerator.
package mips_pkg;

  typedef enum logic [1:0] {
    DST_RT  = 2'd0,
    DST_RD  = 2'd1,
    DST_R31 = 2'd2
  } dst_sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } mem_size_e;

  localparam logic [4:0] REG_LINK = 5'd31;

endpackage

// File: rtl/load_align.sv
// Big-endian load alignment: slices the addressed byte or halfword out of the memory word
// and extends it to 32 bits.
// Ports:
//   mem_data   - word read from data memory
//   offset     - byte offset within the word (address[1:0])
//   size       - SZ_WORD / SZ_HALF / SZ_BYTE (3 is reserved and yields 0, not misaligned)
//   sign_ext   - 1 = sign-extend sub-word result, 0 = zero-extend
//   result     - aligned, extended load value
//   misaligned - offset illegal for the requested size
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] mem_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result,
  output logic        misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // Byte k sits at mem_data[31-8k -: 8] (big-endian).
    unique case (offset)
      2'd0:    byte_v = mem_data[31:24];
      2'd1:    byte_v = mem_data[23:16];
      2'd2:    byte_v = mem_data[15:8];
      default: byte_v = mem_data[7:0];
    endcase
    half_v = offset[1] ? mem_data[15:0] : mem_data[31:16];

    result     = '0;
    misaligned = 1'b0;
    case (size)
      SZ_WORD: begin
        result     = mem_data;
        misaligned = (offset != 2'd0);
      end
      SZ_HALF: begin
        result     = {{16{sign_ext & half_v[15]}}, half_v};
        misaligned = offset[0];
      end
      SZ_BYTE: begin
        result = {{24{sign_ext & byte_v[7]}}, byte_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage of the unpipelined MIPS datapath.
// Resolves destination register and writeback data, registers the register-file write port,
// keeps a one-deep bypass copy of the last committed write, counts retired instructions and
// pulses error flags for misaligned or reserved-encoding instructions (which do not write).
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   valid_in                  - payload is a real instruction (0 = bubble)
//   mem_data, alu_result      - load word and ALU result / effective address
//   r_we, r_dst, rw_d         - write enable, destination select, writeback source select
//   pc, insn                  - instruction address and word
//   mem_read_size, mem_sign_extend - load size and extension
//   rf_we, rf_waddr, rf_wdata - registered register-file write port
//   fwd_valid, fwd_reg, fwd_data - bypass copy of last committed write
//   retire_count              - retired valid instructions (wraps)
//   err_misaligned, err_reserved - one-cycle error pulses
module wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned LINK_OFFSET = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [31:0]      mem_data,
  input  logic [31:0]      alu_result,
  input  logic             r_we,
  input  logic [1:0]       r_dst,
  input  logic [1:0]       rw_d,
  input  logic [31:0]      pc,
  input  logic [31:0]      insn,
  input  logic [1:0]       mem_read_size,
  input  logic             mem_sign_extend,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             fwd_valid,
  output logic [4:0]       fwd_reg,
  output logic [31:0]      fwd_data,
  output logic [CNT_W-1:0] retire_count,
  output logic             err_misaligned,
  output logic             err_reserved
);

  logic [31:0] load_val;
  logic        load_mis;
  logic [4:0]  waddr_d;
  logic [31:0] wdata_d;
  logic        is_load;
  logic        mis_d, res_d, commit_d;

  // Only the rt/rd fields of the instruction word matter here.
  logic unused_insn;
  assign unused_insn = ^{insn[31:21], insn[10:0]};

  load_align u_load_align (
    .mem_data   (mem_data),
    .offset     (alu_result[1:0]),
    .size       (mem_read_size),
    .sign_ext   (mem_sign_extend),
    .result     (load_val),
    .misaligned (load_mis)
  );

  always_comb begin
    waddr_d = '0;
    case (r_dst)
      DST_RT:  waddr_d = insn[20:16];
      DST_RD:  waddr_d = insn[15:11];
      DST_R31: waddr_d = REG_LINK;
      default: waddr_d = '0;
    endcase

    wdata_d = '0;
    case (rw_d)
      WB_ALU:  wdata_d = alu_result;
      WB_MEM:  wdata_d = load_val;
      WB_LINK: wdata_d = pc + 32'(LINK_OFFSET);
      default: wdata_d = '0;
    endcase

    is_load  = (rw_d == WB_MEM);
    // Errors only apply to instructions that actually attempt a register write.
    res_d    = valid_in & r_we & ((r_dst == 2'd3) | (rw_d == 2'd3) |
                                  (is_load & (mem_read_size == 2'd3)));
    mis_d    = valid_in & r_we & is_load & load_mis;
    commit_d = valid_in & r_we & ~res_d & ~mis_d & (waddr_d != 5'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      fwd_valid      <= 1'b0;
      fwd_reg        <= '0;
      fwd_data       <= '0;
      retire_count   <= '0;
      err_misaligned <= 1'b0;
      err_reserved   <= 1'b0;
    end else begin
      rf_we          <= commit_d;
      err_misaligned <= mis_d;
      err_reserved   <= res_d;
      if (commit_d) begin
        rf_waddr  <= waddr_d;
        rf_wdata  <= wdata_d;
        fwd_valid <= 1'b1;
        fwd_reg   <= waddr_d;
        fwd_data  <= wdata_d;
      end
      if (valid_in) begin
        retire_count <= retire_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] mem_data = '0;
  logic [31:0] alu_result = '0;
  logic        r_we = 1'b0;
  logic [1:0]  r_dst = '0;
  logic [1:0]  rw_d = '0;
  logic [31:0] pc = '0;
  logic [31:0] insn = '0;
  logic [1:0]  mem_read_size = '0;
  logic        mem_sign_extend = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic [31:0] retire_count;
  logic        err_misaligned;
  logic        err_reserved;

  wb_stage #(.LINK_OFFSET(8), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .mem_data       (mem_data),
    .alu_result     (alu_result),
    .r_we           (r_we),
    .r_dst          (r_dst),
    .rw_d           (rw_d),
    .pc             (pc),
    .insn           (insn),
    .mem_read_size  (mem_read_size),
    .mem_sign_extend(mem_sign_extend),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .fwd_valid      (fwd_valid),
    .fwd_reg        (fwd_reg),
    .fwd_data       (fwd_data),
    .retire_count   (retire_count),
    .err_misaligned (err_misaligned),
    .err_reserved   (err_reserved)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        fv;
    logic [4:0]  freg;
    logic [31:0] fdata;
    logic [31:0] retire;
    logic        emis;
    logic        eres;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  // Bench-side model of the bypass entry and retire counter.
  logic        m_fv = 1'b0;
  logic [4:0]  m_freg = '0;
  logic [31:0] m_fdata = '0;
  logic [31:0] m_retire = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [4:0] rt, input logic [4:0] rd);
    return {11'h0, rt, rd, 11'h0};
  endfunction

  // Drive one payload at the falling edge and queue its hand-computed response.
  task automatic issue(input string name, input logic v, input logic we, input logic [1:0] dst,
                       input logic [1:0] wb, input logic [31:0] ipc, input logic [31:0] iw,
                       input logic [31:0] alu, input logic [31:0] md, input logic [1:0] sz,
                       input logic sx, input logic e_we, input logic [4:0] e_addr,
                       input logic [31:0] e_data, input logic e_mis, input logic e_res);
    exp_t e;
    @(negedge clk);
    valid_in = v; r_we = we; r_dst = dst; rw_d = wb; pc = ipc; insn = iw;
    alu_result = alu; mem_data = md; mem_read_size = sz; mem_sign_extend = sx;
    if (e_we) begin
      m_fv = 1'b1; m_freg = e_addr; m_fdata = e_data;
    end
    if (v) m_retire = m_retire + 32'd1;
    e.name = name; e.we = e_we; e.waddr = e_addr; e.wdata = e_data;
    e.fv = m_fv; e.freg = m_freg; e.fdata = m_fdata; e.retire = m_retire;
    e.emis = e_mis; e.eres = e_res;
    sb_q.push_back(e);
  endtask

  task automatic bubble(input string name);
    issue(name, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0,
          1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rf_we"}, 32'(rf_we), 32'h0);
    check({tag, " rf_waddr"}, 32'(rf_waddr), 32'h0);
    check({tag, " rf_wdata"}, rf_wdata, 32'h0);
    check({tag, " fwd_valid"}, 32'(fwd_valid), 32'h0);
    check({tag, " fwd_reg"}, 32'(fwd_reg), 32'h0);
    check({tag, " fwd_data"}, fwd_data, 32'h0);
    check({tag, " retire_count"}, retire_count, 32'h0);
    check({tag, " err"}, {30'h0, err_misaligned, err_reserved}, 32'h0);
  endtask

  // Monitor: one registered response per issued payload, sampled after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, " rf_we"}, 32'(rf_we), 32'(e.we));
        if (e.we) begin
          check({e.name, " rf_waddr"}, 32'(rf_waddr), 32'(e.waddr));
          check({e.name, " rf_wdata"}, rf_wdata, e.wdata);
        end
        check({e.name, " fwd_valid"}, 32'(fwd_valid), 32'(e.fv));
        check({e.name, " fwd_reg"}, 32'(fwd_reg), 32'(e.freg));
        check({e.name, " fwd_data"}, fwd_data, e.fdata);
        check({e.name, " retire_count"}, retire_count, e.retire);
        check({e.name, " err_misaligned"}, 32'(err_misaligned), 32'(e.emis));
        check({e.name, " err_reserved"}, 32'(err_reserved), 32'(e.eres));
      end
    end
  end

  task automatic drain();
    int k = 0;
    while (sb_q.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    check("scoreboard drained", 32'(sb_q.size()), 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // name v we dst wb pc insn alu mem sz sx | we addr data mis res
    issue("lb sx off1", 1, 1, 2'd0, 2'd1, 32'h0, mk_insn(5'd5, 5'd0), 32'h1001,
          32'h12F45678, 2'd2, 1, 1, 5'd5, 32'hFFFFFFF4, 0, 0);
    issue("lhu off2", 1, 1, 2'd0, 2'd1, 32'h0, mk_insn(5'd6, 5'd0), 32'h2002,
          32'hAAAA8001, 2'd1, 0, 1, 5'd6, 32'h00008001, 0, 0);
    issue("lhu off1 mis", 1, 1, 2'd0, 2'd1, 32'h0, mk_insn(5'd6, 5'd0), 32'h2001,
          32'hAAAA8001, 2'd1, 0, 0, 5'd0, 32'h0, 1, 0);
    issue("jal link", 1, 1, 2'd2, 2'd2, 32'h00400010, 32'h0, 32'h0,
          32'h0, 2'd0, 0, 1, 5'd31, 32'h00400018, 0, 0);
    issue("jal wrap", 1, 1, 2'd2, 2'd2, 32'hFFFFFFFC, 32'h0, 32'h0,
          32'h0, 2'd0, 0, 1, 5'd31, 32'h00000004, 0, 0);
    issue("write r0", 1, 1, 2'd1, 2'd0, 32'h0, mk_insn(5'd9, 5'd0), 32'h55,
          32'h0, 2'd0, 0, 0, 5'd0, 32'h0, 0, 0);
    issue("bubble we", 0, 1, 2'd1, 2'd0, 32'h0, mk_insn(5'd0, 5'd8), 32'h66,
          32'h0, 2'd0, 0, 0, 5'd0, 32'h0, 0, 0);
    issue("alu r3", 1, 1, 2'd1, 2'd0, 32'h0, mk_insn(5'd0, 5'd3), 32'h33,
          32'h0, 2'd0, 0, 1, 5'd3, 32'h33, 0, 0);
    issue("alu r4", 1, 1, 2'd1, 2'd0, 32'h0, mk_insn(5'd0, 5'd4), 32'h44,
          32'h0, 2'd0, 0, 1, 5'd4, 32'h44, 0, 0);
    issue("alu r5", 1, 1, 2'd1, 2'd0, 32'h0, mk_insn(5'd0, 5'd5), 32'h55,
          32'h0, 2'd0, 0, 1, 5'd5, 32'h55, 0, 0);
    bubble("bubble after b2b");
    issue("lbu off3", 1, 1, 2'd0, 2'd1, 32'h0, mk_insn(5'd10, 5'd0), 32'h3003,
          32'h12F45678, 2'd2, 0, 1, 5'd10, 32'h00000078, 0, 0);
    issue("lh off0 sx", 1, 1, 2'd1, 2'd1, 32'h0, mk_insn(5'd0, 5'd11), 32'h4000,
          32'h8001BEEF, 2'd1, 1, 1, 5'd11, 32'hFFFF8001, 0, 0);
    issue("lw off0", 1, 1, 2'd0, 2'd1, 32'h0, mk_insn(5'd12, 5'd0), 32'h5000,
          32'hDEADBEEF, 2'd0, 1, 1, 5'd12, 32'hDEADBEEF, 0, 0);
    issue("lw off2 mis", 1, 1, 2'd0, 2'd1, 32'h0, mk_insn(5'd12, 5'd0), 32'h5002,
          32'hDEADBEEF, 2'd0, 0, 0, 5'd0, 32'h0, 1, 0);
    issue("rsvd size", 1, 1, 2'd0, 2'd1, 32'h0, mk_insn(5'd13, 5'd0), 32'h6000,
          32'h11223344, 2'd3, 0, 0, 5'd0, 32'h0, 0, 1);
    issue("rsvd r_dst", 1, 1, 2'd3, 2'd0, 32'h0, mk_insn(5'd13, 5'd14), 32'h77,
          32'h0, 2'd0, 0, 0, 5'd0, 32'h0, 0, 1);
    issue("rsvd rw_d", 1, 1, 2'd0, 2'd3, 32'h0, mk_insn(5'd13, 5'd0), 32'h77,
          32'h0, 2'd0, 0, 0, 5'd0, 32'h0, 0, 1);
    bubble("tail bubble");
    drain();

    // Reset asserted between edges while a valid write is on the inputs.
    valid_in = 1; r_we = 1; r_dst = 2'd1; rw_d = 2'd0; insn = mk_insn(5'd0, 5'd20);
    alu_result = 32'hCAFE; mem_read_size = 2'd0;
    #2 rst = 1'b0;
    #1 check_all_zero("async reset");
    @(posedge clk);
    #1 check_all_zero("reset edge");
    @(negedge clk);
    rst = 1'b1;
    valid_in = 0; r_we = 0;
    m_fv = 1'b0; m_freg = '0; m_fdata = '0; m_retire = '0;
    issue("post-reset alu r7", 1, 1, 2'd1, 2'd0, 32'h0, mk_insn(5'd0, 5'd7), 32'h1234,
          32'h0, 2'd0, 0, 1, 5'd7, 32'h1234, 0, 0);
    bubble("post-reset bubble");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the unpipelined MIPS datapath, fed directly by the registered outputs of the memory stage. Each cycle it takes one instruction's payload:

- sub-word slices and sign-extends load data,
- selects the writeback source (ALU result, load data or link address),
- resolves the destination register.

It registers the final register-file write port, keeps a one-deep bypass copy of the last committed write, counts retired instructions and flags misaligned sub-word loads.

## Interface
Parameters:
- LINK_OFFSET, 8, value added to pc for link writes (jal/jalr, delay slot included)
- CNT_W, 32, width of retire counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  payload on the inputs below is a real instruction (0 = bubble)
- mem_data  in  32  word read from data memory (already flopped by memory)
- alu_result  in  32  ALU result / effective address from mem stage
- r_we  in  1  instruction writes a register
- r_dst  in  2  0 = rt, 1 = rd, 2 = r31, 3 = reserved
- rw_d  in  2  0 = ALU, 1 = memory, 2 = pc+LINK_OFFSET, 3 = reserved
- pc  in  32  instruction address
- insn  in  32  instruction word
- mem_read_size  in  2  0 = word, 1 = halfword, 2 = byte, 3 = reserved
- mem_sign_extend  in  1  1 = sign-extend sub-word load, 0 = zero-extend
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- fwd_valid  out  1  bypass entry holds a committed write
- fwd_reg  out  5  register of bypass entry
- fwd_data  out  32  data of bypass entry
- retire_count  out  CNT_W  count of retired valid instructions
- err_misaligned  out  1  one-cycle pulse: misaligned sub-word load suppressed
- err_reserved  out  1  one-cycle pulse: reserved r_dst/rw_d/size encoding suppressed

## Operation

**Destination register**
- r_dst 0 selects insn[20:16].
- r_dst 1 selects insn[15:11].
- r_dst 2 selects 5'd31.

**Writeback data**
- rw_d 0 writes alu_result.
- rw_d 1 writes the aligned load value.
- rw_d 2 writes pc+LINK_OFFSET, mod 2^32, wrapping silently.

**Load alignment (big-endian)**
- Byte offset is alu_result[1:0].
- Byte at offset k is mem_data[31-8k -: 8].
- Halfword at offset 0 is [31:16]; at offset 2 it is [15:0].
- Word loads ignore the offset.
- Extension is by mem_sign_extend.
- Sign bit is bit 7 for bytes and bit 15 for halfwords.
- mem_read_size is consulted only when rw_d = 1.

**Error conditions** (no write, pulse the matching error output)
- Misaligned: rw_d = 1 with a word load and alu_result[1:0] ≠ 0, or a halfword load and alu_result[0] = 1.
- Reserved: r_dst = 3, rw_d = 3, or (rw_d = 1 and mem_read_size = 3).

**Write commit**
- Commit when valid_in & r_we & no error & destination ≠ 0.
- A write to r0 is dropped silently. It raises no error, but the instruction still retires.

**Retirement and bypass**
- retire_count increments by 1 for every valid_in = 1 cycle, errors included, and wraps at 2^CNT_W.
- The bypass entry loads {1, waddr, wdata} on every commit.
- Otherwise the bypass entry holds its value; bubbles and suppressed writes do not clear it.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on rf_*, fwd_*, err_* and retire_count after edge N.
- rf_we is high exactly one cycle per commit.
- Back-to-back commits are supported every cycle.
- err_* pulse for one cycle and never coincide with rf_we = 1.
- Reset (asynchronous assert, synchronous deassert in the clock domain) forces all outputs to 0:
  - rf_we, rf_waddr, rf_wdata
  - fwd_valid, fwd_reg, fwd_data
  - retire_count
  - err_*
- Reset asserted mid-stream discards the in-flight payload; nothing is committed on the reset edge.
- The first sample after deassert occurs on the first rising edge with rst = 1.
- No handshake or stall: the stage accepts every cycle, and upstream signals bubbles with valid_in = 0.

## Structure
- Shared package mips_pkg holds:
  - enums for r_dst (DST_RT, DST_RD, DST_R31), rw_d (WB_ALU, WB_MEM, WB_LINK) and size (SZ_WORD, SZ_HALF, SZ_BYTE)
  - the constant REG_LINK = 5'd31
- One combinational sub-module, load_align, takes (mem_data, offset, size, sign_ext) and returns a 32-bit result plus a misaligned flag.
- All state lives in wb_stage: output registers, bypass entry and counter.

## Test plan
- **Byte load, sign-extend:** mem_data = 32'h12F45678, alu_result[1:0] = 1, rw_d = 1, size = byte, sign_ext = 1, r_dst = 0, insn[20:16] = 5 → next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 32'hFFFFFFF4.
- **Halfword load, zero-extend:** offset 2, mem_data = 32'hAAAA8001, sign_ext = 0 → rf_wdata = 32'h00008001. The same load at offset 1 → err_misaligned = 1, rf_we = 0, retire_count still +1.
- **Link write:** rw_d = 2, r_dst = 2, pc = 32'h00400010 → rf_waddr = 31, rf_wdata = 32'h00400018. With pc = 32'hFFFFFFFC → rf_wdata = 32'h00000004.
- **r0 and bubbles:** r_dst = 1 with insn[15:11] = 0 → rf_we = 0, fwd unchanged, no err. valid_in = 0 with r_we = 1 → no write and retire_count unchanged.
- **Back-to-back commits and bypass:** 3 consecutive ALU writes to r3, r4, r5 → rf_we high 3 cycles, fwd_reg tracks 3, 4, 5. A following bubble leaves fwd_reg = 5, fwd_valid = 1.
- **Reset mid-stream:** assert rst low between clock edges during a valid write → all outputs 0 immediately. After release, the first valid instruction gives retire_count = 1.
